alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one external 32-bit ALU between two requesters. The ALU uses ctl codes 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- Arbitrates requests round-robin and latches the operands.
- Drives the ALU for one cycle, registers the result and zero flag, and returns them to the granted requester over a valid/ready response handshake.
- Sits between the two issue units and the shared ALU instance.

Parameters:
- WIDTH, 32, datapath width of operands and result.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand a.
- req0_b  input  WIDTH  requester 0 operand b.
- req0_ctl  input  4  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctl: same as the requester 0 ports, for requester 1.
- rsp0_valid  output  1  result available for requester 0.
- rsp0_ready  input  1  requester 0 takes the result.
- rsp1_valid  output  1  result available for requester 1.
- rsp1_ready  input  1  requester 1 takes the result.
- rsp_result  output  WIDTH  registered result, shared by both response channels.
- rsp_zero  output  1  registered zero flag.
- rsp_err  output  1  the operation had an illegal ctl code.
- alu_a  output  WIDTH  to ALU operand a.
- alu_b  output  WIDTH  to ALU operand b.
- alu_ctl  output  4  to ALU control.
- alu_out  input  WIDTH  from ALU result, combinational.
- alu_zero  input  2  from ALU zero flag; only bit 0 is used.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All outputs 0: ready, rsp valids, rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctl, busy.
  - last_grant=1, so requester 0 wins the first contention.
  - An in-flight operation is discarded and no response is issued.
- State IDLE:
  - reqN_ready is combinational: (state==IDLE) && grant==N. At most one ready is high.
  - Grant rule:
    - Only one valid: that requester is granted.
    - Both valid: requester !last_grant is granted.
  - On handshake (valid&&ready): latch a, b, ctl and grant index, set last_grant=grant, then go to EXEC.
  - No valid: stay in IDLE.
- State EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_ctl are driven from the latched registers; they are driven only in EXEC and are 0 otherwise.
  - Legal ctl code: rsp_result<=alu_out, rsp_zero<=alu_zero[0], rsp_err<=0.
  - Illegal ctl code (anything other than the five listed): ALU output is ignored; rsp_result<=0, rsp_zero<=1, rsp_err<=1.
  - Then go to RESP.
- State RESP:
  - rspN_valid=1 for the granted N only. It is registered and asserted the cycle after EXEC.
  - rsp_result, rsp_zero and rsp_err are held stable while valid is high.
  - On rspN_ready: next cycle valid is 0 and state returns to IDLE.
  - rspN_ready while the matching valid is low is ignored.
  - The response waits indefinitely for ready.
- Latency: accept at cycle T, EXEC at T+1, rsp valid visible from T+2. Peak throughput is one operation per 3 cycles when the response is taken immediately.
- Simultaneous events:
  - Valids arriving while not in IDLE are held off (ready=0); requesters must keep valid and operands stable until ready.
  - A response handshake and a new request in the same cycle: the new request is accepted in the following IDLE cycle, not in RESP.
- Arithmetic:
  - Operand widths are unchanged.
  - The SLT result comes from the ALU: 1 or 0, zero-extended, unsigned compare.
  - SUB wraps modulo 2^WIDTH.
- rsp_result persists after the handshake until the next EXEC overwrites it.

Test Plan:
- Single op: req0 a=5, b=3, ctl=0010 valid at T; ALU model attached -> req0_ready at T; alu_ctl=0010 at T+1; rsp0_valid at T+2 with rsp_result=8, zero=0, err=0; rsp1_valid stays 0.
- Contention fairness: req0 and req1 both valid continuously with rsp_ready tied 1 -> grants alternate 0,1,0,1 over 4 ops, each 3 cycles apart.
- Zero/wrap: req1 SUB a=7, b=7 -> result 0, zero=1. Then SUB a=0, b=1 -> result 32'hFFFFFFFF, zero=0.
- Illegal ctl: req0 ctl=0011, a=1, b=1 -> rsp_result=0, zero=1, err=1; ALU output is not used.
- Response backpressure: rsp0_ready held 0 for 5 cycles -> rsp0_valid and the result stay stable; req1_valid asserted meanwhile gets ready=0 until one cycle after the rsp0 handshake.
- Async reset mid-EXEC: rst_n low between clock edges -> all outputs 0 immediately; after release, req0 and req1 both valid -> req0 is granted first.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Bundle of every non-clock/reset signal of alu_share_arbiter:
//   requester channels  : req{0,1}_valid/ready/a/b/ctl
//   response channels   : rsp{0,1}_valid/ready, shared rsp_result/zero/err
//   shared ALU hookup   : alu_a/b/ctl out, alu_out/alu_zero back
//   status              : busy
// slave  = arbiter side, master = issue units + ALU side.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_ctl;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_ctl;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] alu_out;
    logic [1:0]       alu_zero;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctl,
        input  req1_valid, req1_a, req1_b, req1_ctl,
        input  rsp0_ready, rsp1_ready, alu_out, alu_zero,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctl, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctl,
        output req1_valid, req1_a, req1_b, req1_ctl,
        output rsp0_ready, rsp1_ready, alu_out, alu_zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_zero, rsp_err, alu_a, alu_b, alu_ctl, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters. Round-robin grant in IDLE,
// operands latched on accept, ALU driven for one EXEC cycle, result/zero/err
// registered and returned on the granted response channel.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_share_arbiter_if.slave (requests, responses, ALU hookup, busy)
//
// state | meaning
// IDLE  | waiting for a request; ready offered to the granted requester
// EXEC  | latched operands on the ALU, result captured at end of cycle
// RESP  | response valid on the granted channel until taken
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             gnt_q, gnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       ctl_q, ctl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;

    logic grant;
    logic any_valid;
    logic ctl_legal;
    logic rsp_taken;
    logic unused_alu_zero_hi;

    assign unused_alu_zero_hi = bus.alu_zero[1];

    // With both valid, the requester that did not win last time goes first.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant     = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    assign ctl_legal = ctl_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    assign rsp_taken = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        a_d          = a_q;
        b_d          = b_q;
        ctl_d        = ctl_q;
        result_d     = result_q;
        zero_d       = zero_q;
        err_d        = err_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    gnt_d        = grant;
                    last_grant_d = grant;
                    a_d          = grant ? bus.req1_a   : bus.req0_a;
                    b_d          = grant ? bus.req1_b   : bus.req0_b;
                    ctl_d        = grant ? bus.req1_ctl : bus.req0_ctl;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (ctl_legal) begin
                    result_d = bus.alu_out;
                    zero_d   = bus.alu_zero[0];
                    err_d    = 1'b0;
                end else begin
                    result_d = '0;
                    zero_d   = 1'b1;
                    err_d    = 1'b1;
                end
                rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_taken) begin
                    rsp_valid_d = 2'b00;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            ctl_q        <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ctl_q        <= ctl_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign bus.req0_ready = (state_q == IDLE) && bus.req0_valid && !grant;
    assign bus.req1_ready = (state_q == IDLE) && bus.req1_valid &&  grant;
    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;
    // ALU inputs are only live during EXEC so the shared ALU sees quiet zeros otherwise.
    assign bus.alu_a      = (state_q == EXEC) ? a_q   : '0;
    assign bus.alu_b      = (state_q == EXEC) ? b_q   : '0;
    assign bus.alu_ctl    = (state_q == EXEC) ? ctl_q : 4'b0000;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic last_model;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(32)) bus ();

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // External ALU: illegal codes produce non-zero junk that must never reach rsp_result.
    // alu_zero[1] is the inverse of the real flag so use of the wrong bit is visible.
    always_comb begin
        case (bus.alu_ctl)
            4'b0000: bus.alu_out = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_out = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_out = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_out = bus.alu_a - bus.alu_b;
            4'b0111: bus.alu_out = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
            default: bus.alu_out = bus.alu_a ^ bus.alu_b ^ 32'hA5A5_5A5A;
        endcase
    end
    assign bus.alu_zero = {bus.alu_out != 0, bus.alu_out == 0};

    // Expected {err, zero, result} from the operation's meaning.
    function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl);
        logic [31:0] r;
        case (ctl)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = 32'(a + b);
            4'd6: r = 32'(a - b);
            4'd7: r = (a < b) ? 32'd1 : 32'd0;
            default: return {1'b1, 1'b1, 32'd0};
        endcase
        return {1'b0, r == 32'd0, r};
    endfunction

    function automatic logic [3:0] rand_ctl();
        logic [3:0] legal [5] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return legal[$urandom_range(0, 4)];
    endfunction

    task automatic set_req(input int idx, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl);
        if (idx == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ctl = ctl;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ctl = ctl;
        end
    endtask

    task automatic set_rsp_ready(input int idx, input logic v);
        if (idx == 0) bus.rsp0_ready = v;
        else          bus.rsp1_ready = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_model = 1'b1;
    endtask

    // One complete transaction on requester idx, response held off for 'hold' cycles.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ctl, input int hold, input string name);
        logic [33:0] exp;
        logic        rdy;
        int          waited;
        exp = ref_alu(a, b, ctl);
        @(negedge clk);
        set_req(idx, 1'b1, a, b, ctl);
        #1;
        rdy = (idx == 0) ? bus.req0_ready : bus.req1_ready;
        waited = 0;
        while (!rdy && waited < 20) begin
            @(negedge clk); #1;
            rdy = (idx == 0) ? bus.req0_ready : bus.req1_ready;
            waited++;
        end
        checks++;
        if (rdy !== 1'b1 || waited != 0) begin
            $display("FAIL %s ready: got %b after %0d cycles, expected 1 immediately", name, rdy, waited);
            errors++;
            set_req(idx, 1'b0, 32'd0, 32'd0, 4'd0);
            return;
        end
        checks++;
        if (((idx == 0) ? bus.req1_ready : bus.req0_ready) !== 1'b0) begin
            $display("FAIL %s other_ready: got 1, expected 0", name); errors++;
        end
        @(negedge clk);
        set_req(idx, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_ctl, bus.busy} !== {a, b, ctl, 1'b1}) begin
            $display("FAIL %s exec_drive: got a=%h b=%h ctl=%h busy=%b, expected a=%h b=%h ctl=%h busy=1",
                     name, bus.alu_a, bus.alu_b, bus.alu_ctl, bus.busy, a, b, ctl);
            errors++;
        end
        checks++;
        if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b00) begin
            $display("FAIL %s early_valid: got %b, expected 00", name, {bus.rsp1_valid, bus.rsp0_valid}); errors++;
        end
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({bus.rsp1_valid, bus.rsp0_valid} !== ((idx == 0) ? 2'b01 : 2'b10)) begin
                $display("FAIL %s rsp_valid: got %b at hold %0d, expected %b", name,
                         {bus.rsp1_valid, bus.rsp0_valid}, i, (idx == 0) ? 2'b01 : 2'b10);
                errors++;
            end
            checks++;
            if ({bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== exp) begin
                $display("FAIL %s rsp_data: got err=%b zero=%b res=%h, expected err=%b zero=%b res=%h",
                         name, bus.rsp_err, bus.rsp_zero, bus.rsp_result, exp[33], exp[32], exp[31:0]);
                errors++;
            end
            checks++;
            if ({bus.alu_a, bus.alu_b, bus.alu_ctl} !== '0) begin
                $display("FAIL %s alu_idle: got a=%h b=%h ctl=%h, expected 0", name, bus.alu_a, bus.alu_b, bus.alu_ctl);
                errors++;
            end
        end
        set_rsp_ready(idx, 1'b1);
        @(negedge clk);
        set_rsp_ready(idx, 1'b0);
        #1;
        checks++;
        if ({bus.rsp1_valid, bus.rsp0_valid, bus.busy} !== 3'b000 || bus.rsp_result !== exp[31:0]) begin
            $display("FAIL %s after_ack: got valid=%b busy=%b res=%h, expected valid=00 busy=0 res=%h",
                     name, {bus.rsp1_valid, bus.rsp0_valid}, bus.busy, bus.rsp_result, exp[31:0]);
            errors++;
        end
        last_model = idx[0];
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_result, bus.rsp_zero,
             bus.rsp_err, bus.alu_a, bus.alu_b, bus.alu_ctl, bus.busy} !== '0) begin
            $display("FAIL reset_outputs: got busy=%b res=%h ctl=%h, expected all 0", bus.busy, bus.rsp_result, bus.alu_ctl);
            errors++;
        end
        // Response ready with no response pending must do nothing.
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== 3'b000) begin
            $display("FAIL stray_rsp_ready: got valid=%b%b busy=%b, expected 000", bus.rsp0_valid, bus.rsp1_valid, bus.busy);
            errors++;
        end
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic test_single_op();
        run_op(0, 32'd5, 32'd3, 4'b0010, 0, "single_add");
    endtask

    task automatic test_zero_wrap();
        run_op(1, 32'd7, 32'd7, 4'b0110, 0, "sub_zero");
        run_op(1, 32'd0, 32'd1, 4'b0110, 0, "sub_wrap");
        run_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0111, 0, "slt_unsigned");
    endtask

    task automatic test_illegal();
        run_op(0, 32'd1, 32'd1, 4'b0011, 0, "illegal_ctl");
    endtask

    task automatic test_backpressure();
        logic [31:0] a0, b0, a1, b1;
        logic [33:0] exp0, exp1;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        exp0 = ref_alu(a0, b0, 4'b0010);
        exp1 = ref_alu(a1, b1, 4'b0001);
        @(negedge clk);
        set_req(0, 1'b1, a0, b0, 4'b0010);
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1) begin
            $display("FAIL bp_accept0: got %b, expected 1", bus.req0_ready); errors++;
        end
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b1, a1, b1, 4'b0001);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.rsp0_valid !== 1'b1 || bus.req1_ready !== 1'b0 ||
                {bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== exp0) begin
                $display("FAIL bp_hold: cycle %0d got valid=%b req1_ready=%b res=%h, expected valid=1 req1_ready=0 res=%h",
                         i, bus.rsp0_valid, bus.req1_ready, bus.rsp_result, exp0[31:0]);
                errors++;
            end
            @(negedge clk);
        end
        bus.rsp0_ready = 1'b1;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b0 || bus.rsp0_valid !== 1'b1) begin
            $display("FAIL bp_handshake_cycle: got req1_ready=%b rsp0_valid=%b, expected 0 and 1", bus.req1_ready, bus.rsp0_valid);
            errors++;
        end
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        #1;
        checks++;
        if (bus.rsp0_valid !== 1'b0 || bus.req1_ready !== 1'b1 || bus.rsp_result !== exp0[31:0]) begin
            $display("FAIL bp_next_accept: got rsp0_valid=%b req1_ready=%b res=%h, expected 0 1 %h",
                     bus.rsp0_valid, bus.req1_ready, bus.rsp_result, exp0[31:0]);
            errors++;
        end
        @(negedge clk);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || {bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== exp1) begin
            $display("FAIL bp_req1_rsp: got v1=%b v0=%b res=%h, expected 1 0 %h", bus.rsp1_valid, bus.rsp0_valid, bus.rsp_result, exp1[31:0]);
            errors++;
        end
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        bus.rsp1_ready = 1'b0;
        last_model = 1'b1;
    endtask

    // Both requesters always valid with random operations, responses always taken.
    task automatic test_contention_random();
        logic [31:0] a [2];
        logic [31:0] b [2];
        logic [3:0]  c [2];
        logic [34:0] expq [$];
        logic [34:0] e;
        int  accepts = 0;
        int  prev_acc = -1;
        int  upd = -1;
        int  cyc = 0;
        int  drain = 0;
        int  idx;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            a[r] = $urandom; b[r] = ($urandom_range(0, 3) == 0) ? a[r] : $urandom; c[r] = rand_ctl();
        end
        while (cyc < 80 && drain < 4) begin
            @(negedge clk);
            if (upd >= 0) begin
                a[upd] = $urandom; b[upd] = ($urandom_range(0, 3) == 0) ? a[upd] : $urandom; c[upd] = rand_ctl();
                upd = -1;
            end
            set_req(0, accepts < 12, a[0], b[0], c[0]);
            set_req(1, accepts < 12, a[1], b[1], c[1]);
            if (accepts >= 12) drain++;
            #1;
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    $display("FAIL cont_unexpected_rsp: got valid=%b%b, expected none", bus.rsp1_valid, bus.rsp0_valid);
                    errors++;
                end else begin
                    e = expq.pop_front();
                    if ({bus.rsp1_valid, bus.rsp0_valid} !== (e[34] ? 2'b10 : 2'b01) ||
                        {bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== e[33:0]) begin
                        $display("FAIL cont_rsp: got valid=%b err=%b zero=%b res=%h, expected req%0d err=%b zero=%b res=%h",
                                 {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp_err, bus.rsp_zero, bus.rsp_result,
                                 e[34], e[33], e[32], e[31:0]);
                        errors++;
                    end
                end
            end
            if (bus.req0_ready || bus.req1_ready) begin
                idx = bus.req1_ready ? 1 : 0;
                checks++;
                if ((bus.req0_ready && bus.req1_ready) || idx[0] !== ~last_model ||
                    (prev_acc >= 0 && cyc - prev_acc != 3)) begin
                    $display("FAIL cont_grant: got ready=%b%b gap=%0d, expected req%0d with gap 3",
                             bus.req1_ready, bus.req0_ready, cyc - prev_acc, ~last_model);
                    errors++;
                end
                expq.push_back({idx[0], ref_alu(a[idx], b[idx], c[idx])});
                last_model = idx[0];
                prev_acc = cyc;
                upd = idx;
                accepts++;
            end
            cyc++;
        end
        checks++;
        if (accepts != 12 || expq.size() != 0) begin
            $display("FAIL cont_count: got %0d accepts, %0d responses pending, expected 12 and 0", accepts, expq.size());
            errors++;
        end
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        set_req(0, 1'b1, 32'd9, 32'd4, 4'b0110);
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.alu_ctl !== 4'b0110) begin
            $display("FAIL rst_in_exec: got busy=%b ctl=%h, expected 1 and 6", bus.busy, bus.alu_ctl); errors++;
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_result, bus.rsp_zero,
             bus.rsp_err, bus.alu_a, bus.alu_b, bus.alu_ctl, bus.busy} !== '0) begin
            $display("FAIL rst_async_outputs: got busy=%b a=%h ctl=%h res=%h, expected all 0",
                     bus.busy, bus.alu_a, bus.alu_ctl, bus.rsp_result);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_model = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== 3'b000) begin
            $display("FAIL rst_discard: got valid=%b%b busy=%b, expected 000", bus.rsp0_valid, bus.rsp1_valid, bus.busy);
            errors++;
        end
        set_req(0, 1'b1, 32'd2, 32'd2, 4'b0000);
        set_req(1, 1'b1, 32'd3, 32'd3, 4'b0001);
        #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            $display("FAIL rst_first_grant: got ready=%b, expected 01", {bus.req1_ready, bus.req0_ready}); errors++;
        end
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp_result !== 32'd2) begin
            $display("FAIL rst_first_rsp: got valid=%b res=%h, expected 1 and 2", bus.rsp0_valid, bus.rsp_result); errors++;
        end
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        last_model = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_zero_wrap();
        test_illegal();
        test_backpressure();
        test_contention_random();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
